seg7_scan_driver: RTL and testbench

Time-multiplexed driver for an NDIGITS common-anode seven-segment display. It generalises single-digit hex decoding into a parametrised multi-digit scanner with a refresh prescaler, per-digit decimal points, and optional leading-zero blanking. New values are double-buffered and applied only at frame boundaries, so the display never shows a partial update. It sits between a Nios II PIO or register bank and the board's shared segment and anode pins.

---
 rtl/seg7_scan_driver.sv | 119 +++++++++++
 tb/tb_seg7_scan_driver.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed NDIGITS seven-segment scanner with frame-synchronous double-buffered updates
//   iCLK, iRST (async, active-high)
//   iEN       scan enable (low: frozen scan, dark display)
//   iLOAD     strobe capturing iVALUE/iDP/iBLANK_LZ into the shadow register
//   iVALUE    hex nibbles, nibble k drives digit k
//   iDP       per-digit decimal-point request
//   iBLANK_LZ leading-zero blanking enable
//   o7SEG     {g,f,e,d,c,b,a} active-low, oDP active-low
//   oAN       active-low anode selects, oFRAME one-cycle pulse per frame
module seg7_scan_driver #(
  parameter int NDIGITS = 4,
  parameter int DIV = 50000
) (
  input  logic                   iCLK,
  input  logic                   iRST,
  input  logic                   iEN,
  input  logic                   iLOAD,
  input  logic [4*NDIGITS-1:0]   iVALUE,
  input  logic [NDIGITS-1:0]     iDP,
  input  logic                   iBLANK_LZ,
  output logic [6:0]             o7SEG,
  output logic                   oDP,
  output logic [NDIGITS-1:0]     oAN,
  output logic                   oFRAME
);
  localparam int CW = $clog2(DIV);
  localparam int IW = NDIGITS > 1 ? $clog2(NDIGITS) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [4*NDIGITS-1:0] act_val_q, sh_val_q;
  logic [NDIGITS-1:0] act_dp_q, sh_dp_q, an_q, an_d, lz;
  logic act_blz_q, sh_blz_q, pend_q, dead_q, frame_q, dp_q, dp_d, tick, wrap, blank;
  logic [6:0] seg_q, seg_d;
  logic [3:0] nib;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    tick = iEN && cnt_q == CW'(DIV - 1);
    wrap = tick && idx_q == IW'(NDIGITS - 1);
    cnt_d = !iEN ? cnt_q : tick ? '0 : cnt_q + 1'b1;
    idx_d = wrap ? '0 : tick ? idx_q + 1'b1 : idx_q;
    // lz[k]: nibbles k..NDIGITS-1 are all zero
    lz = '0;
    lz[NDIGITS-1] = act_val_q[4*NDIGITS-1 -: 4] == 4'h0;
    for (int k = NDIGITS - 2; k >= 0; k--) lz[k] = lz[k+1] && act_val_q[4*k +: 4] == 4'h0;
    nib = act_val_q[4*idx_q +: 4];
    blank = act_blz_q && idx_q != '0 && lz[idx_q];
    seg_d = blank ? 7'h7F : hex7(nib);
    dp_d = ~act_dp_q[idx_q];
    // dead_q marks the first cycle on a new digit: anodes stay off to avoid ghosting
    an_d = (iEN && !dead_q) ? ~(NDIGITS'(1) << idx_q) : '1;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      cnt_q <= '0;
      idx_q <= '0;
      act_val_q <= '0;
      act_dp_q <= '0;
      act_blz_q <= 1'b0;
      sh_val_q <= '0;
      sh_dp_q <= '0;
      sh_blz_q <= 1'b0;
      pend_q <= 1'b0;
      dead_q <= 1'b1;
      frame_q <= 1'b0;
      seg_q <= '1;
      dp_q <= 1'b1;
      an_q <= '1;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      dead_q <= tick;
      frame_q <= wrap;
      seg_q <= seg_d;
      dp_q <= dp_d;
      an_q <= an_d;
      if (iLOAD) begin
        sh_val_q <= iVALUE;
        sh_dp_q <= iDP;
        sh_blz_q <= iBLANK_LZ;
      end
      // a load on the wrap itself bypasses the shadow so it is not delayed a frame
      if (wrap) begin
        act_val_q <= iLOAD ? iVALUE : pend_q ? sh_val_q : act_val_q;
        act_dp_q <= iLOAD ? iDP : pend_q ? sh_dp_q : act_dp_q;
        act_blz_q <= iLOAD ? iBLANK_LZ : pend_q ? sh_blz_q : act_blz_q;
        pend_q <= 1'b0;
      end else if (iLOAD) begin
        pend_q <= 1'b1;
      end
    end
  end

  assign o7SEG = seg_q;
  assign oDP = dp_q;
  assign oAN = an_q;
  assign oFRAME = frame_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: self-checking bench for seg7_scan_driver (NDIGITS=4, DIV=4)
module tb_seg7_scan_driver;
  logic clk = 1'b0;
  logic rst, en, load, blz;
  logic [15:0] val;
  logic [3:0] dp, an;
  logic [6:0] seg;
  logic dpo, frame;

  always #5 clk = ~clk;

  seg7_scan_driver #(.NDIGITS(4), .DIV(4)) dut (
    .iCLK(clk), .iRST(rst), .iEN(en), .iLOAD(load), .iVALUE(val), .iDP(dp),
    .iBLANK_LZ(blz), .o7SEG(seg), .oDP(dpo), .oAN(an), .oFRAME(frame)
  );

  typedef struct {
    logic [15:0] v;
    logic [3:0] d;
    logic b;
    logic [27:0] s;
    logic [3:0] p;
  } vec_t;
  typedef struct {
    logic [3:0] an;
    logic [6:0] s;
    logic p;
  } exp_t;

  vec_t vt[7];
  vec_t v5, vz;
  exp_t q[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic load_vec(input vec_t x);
    val = x.v;
    dp = x.d;
    blz = x.b;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic push_vec(input vec_t x);
    for (int k = 0; k < 4; k++) q.push_back('{an: 4'hF ^ (4'h1 << k), s: x.s[7*k +: 7], p: x.p[k]});
  endtask

  task automatic wait_frame;
    int n = 0;
    while (frame !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("frame_seen", frame, 1);
  endtask

  task automatic wait_an(input logic [3:0] x);
    int n = 0;
    while (an !== x && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("an_seen", an, x);
  endtask

  task automatic check_digits;
    exp_t e;
    int n;
    @(negedge clk);
    check("dead", an, 4'hF);
    repeat (4) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: got 0 entries expected 1");
      end else begin
        e = q.pop_front();
        n = 0;
        while (an === 4'hF && n < 10) begin
          @(negedge clk);
          n++;
        end
        check("an", an, e.an);
        check("seg", seg, e.s);
        check("dp", dpo, e.p);
        n = 0;
        while (an === e.an && n < 10) begin
          n++;
          @(negedge clk);
        end
        check("low_cycles", n, 3);
      end
    end
  endtask

  initial begin
    int n;
    vt[0] = '{16'h12AF, 4'b0000, 1'b0, {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}, 4'b1111};
    vt[1] = '{16'h0070, 4'b1000, 1'b1, {7'h7F, 7'h7F, 7'b1111000, 7'b1000000}, 4'b0111};
    vt[2] = '{16'h0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'b1000000}, 4'b1111};
    vt[3] = '{16'h1234, 4'b0101, 1'b0, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'b1010};
    vt[4] = '{16'h0B0C, 4'b0010, 1'b1, {7'h7F, 7'b0000011, 7'b1000000, 7'b1000110}, 4'b1101};
    vt[5] = '{16'h9E6D, 4'b1111, 1'b1, {7'b0010000, 7'b0000110, 7'b0000010, 7'b0100001}, 4'b0000};
    vt[6] = '{16'h8573, 4'b0000, 1'b0, {7'b0000000, 7'b0010010, 7'b1111000, 7'b0110000}, 4'b1111};
    v5 = '{16'h5555, 4'b0000, 1'b0, {4{7'b0010010}}, 4'b1111};
    vz = '{16'h0000, 4'b0000, 1'b0, {4{7'b1000000}}, 4'b1111};
    rst = 1'b1;
    en = 1'b1;
    load = 1'b0;
    val = '0;
    dp = '0;
    blz = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", dpo, 1);
    check("rst_frame", frame, 0);
    rst = 1'b0;
    load_vec(vt[0]);
    check("first_dead", an, 4'hF);
    @(negedge clk);
    check("first_an", an, 4'b1110);
    check("first_seg", seg, 7'b1000000);
    push_vec(vt[0]);
    wait_frame();
    check_digits();
    for (int i = 1; i < 7; i++) begin
      load_vec(vt[i]);
      push_vec(vt[i]);
      wait_frame();
      check_digits();
    end
    // frame period and pulse width
    wait_frame();
    @(negedge clk);
    check("frame_width", frame, 0);
    n = 1;
    while (frame !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("frame_period", n, 16);
    // tear-free update
    load_vec(vt[3]);
    push_vec(vt[3]);
    wait_frame();
    check_digits();
    wait_an(4'b1101);
    load_vec(v5);
    wait_an(4'b1011);
    check("tear_d2", seg, 7'b0100100);
    wait_an(4'b0111);
    check("tear_d3", seg, 7'b1111001);
    push_vec(v5);
    wait_frame();
    check_digits();
    // load coincident with the wrapping tick
    wait_frame();
    repeat (15) @(negedge clk);
    push_vec(vt[5]);
    load_vec(vt[5]);
    check("frame_on_load", frame, 1);
    check_digits();
    // enable gating mid-digit, with a load while frozen
    wait_an(4'b1101);
    en = 1'b0;
    load_vec(vt[0]);
    push_vec(vt[0]);
    repeat (9) begin
      @(negedge clk);
      check("off_an", an, 4'hF);
      check("off_frame", frame, 0);
    end
    en = 1'b1;
    n = 0;
    @(negedge clk);
    while (an === 4'b1101 && n < 10) begin
      n++;
      @(negedge clk);
    end
    check("resume_remaining", n, 2);
    check("resume_dead", an, 4'hF);
    @(negedge clk);
    check("resume_next", an, 4'b1011);
    wait_frame();
    check_digits();
    // asynchronous reset mid-scan discards pending data
    wait_an(4'b1011);
    load_vec(vt[3]);
    #2 rst = 1'b1;
    #1;
    check("arst_an", an, 4'hF);
    check("arst_seg", seg, 7'h7F);
    check("arst_dp", dpo, 1);
    check("arst_frame", frame, 0);
    #1 rst = 1'b0;
    push_vec(vz);
    wait_frame();
    check_digits();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
